// File: rtl/uart_regs_pkg.sv
// ============================================================================
// Module   : uart_regs_pkg
// Brief    : Register map, bit indices and TX dispatch states for the UART
//            MMIO front-end.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_regs_pkg;

    localparam logic [1:0] c_sel_ctrl   = 2'b00;
    localparam logic [1:0] c_sel_txdata = 2'b01;
    localparam logic [1:0] c_sel_rxdata = 2'b10;
    localparam logic [1:0] c_sel_status = 2'b11;

    localparam int c_ctrl_parity_en = 0;
    localparam int c_ctrl_rx_irq_en = 1;
    localparam int c_ctrl_tx_irq_en = 2;
    localparam int c_ctrl_rx_flush  = 3;
    localparam int c_ctrl_tx_flush  = 4;

    localparam int c_st_rx_empty    = 0;
    localparam int c_st_rx_full     = 1;
    localparam int c_st_tx_empty    = 2;
    localparam int c_st_tx_full     = 3;
    localparam int c_st_tx_busy     = 4;
    localparam int c_st_rx_ovf      = 5;
    localparam int c_st_tx_ovf      = 6;
    localparam int c_st_rx_cnt_lsb  = 8;
    localparam int c_st_tx_cnt_lsb  = 16;

    localparam int c_rx_valid_bit   = 10;
    localparam int c_rx_parity_bit  = 9;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_BUSY  = 2'd2
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with flush; a push into a full FIFO succeeds
//            only when a pop happens on the same edge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Flush overrides both operations; a pop frees the slot a full push needs.
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/uart_mmio_fifo_regs.sv
// ============================================================================
// Module   : uart_mmio_fifo_regs
// Brief    : Bus register front-end for the UART with RX/TX FIFOs, sticky
//            overrun flags, interrupt and TX dispatch FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_mmio_fifo_regs
    import uart_regs_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int RX_DEPTH = 8,
    parameter int TX_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        reg_sel,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_parity_err,
    input  logic              rx_done,
    input  logic              tx_done,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_parity_en,
    output logic              tx_start,
    output logic              irq
);

    localparam int c_rx_aw = $clog2(RX_DEPTH);
    localparam int c_tx_aw = $clog2(TX_DEPTH);

    logic [2:0]        r_ctrl;
    logic              r_rx_ovf;
    logic              r_tx_ovf;
    logic              r_irq;
    logic [DATA_W-1:0] r_tx_data;
    tx_state_t         r_state;
    tx_state_t         w_state_next;

    logic              w_wr_ctrl;
    logic              w_wr_status;
    logic              w_rx_flush;
    logic              w_tx_flush;
    logic              w_rx_pop;
    logic              w_tx_push;
    logic              w_tx_pop;
    logic              w_rx_empty;
    logic              w_rx_full;
    logic              w_tx_empty;
    logic              w_tx_full;
    logic [DATA_W:0]   w_rx_head;
    logic [DATA_W-1:0] w_tx_head;
    logic [c_rx_aw:0]  w_rx_count;
    logic [c_tx_aw:0]  w_tx_count;
    logic              w_rx_ovf_set;
    logic              w_tx_ovf_set;
    logic              w_unused_wdata;

    assign w_wr_ctrl   = wr_en & (reg_sel == c_sel_ctrl);
    assign w_wr_status = wr_en & (reg_sel == c_sel_status);
    assign w_rx_flush  = w_wr_ctrl & wdata[c_ctrl_rx_flush];
    assign w_tx_flush  = w_wr_ctrl & wdata[c_ctrl_tx_flush];
    assign w_rx_pop    = rd_en & (reg_sel == c_sel_rxdata);
    assign w_tx_push   = wr_en & (reg_sel == c_sel_txdata);

    assign w_rx_ovf_set = rx_done & w_rx_full & ~(w_rx_pop & ~w_rx_flush) & ~w_rx_flush;
    assign w_tx_ovf_set = w_tx_push & w_tx_full & ~w_tx_pop & ~w_tx_flush;
    assign w_unused_wdata = ^wdata;

    sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (rx_done),
        .i_data  ({rx_parity_err, rx_data}),
        .i_pop   (w_rx_pop),
        .i_flush (w_rx_flush),
        .o_data  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_tx_push),
        .i_data  (wdata[DATA_W-1:0]),
        .i_pop   (w_tx_pop),
        .i_flush (w_tx_flush),
        .o_data  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    // Set beats a same-cycle W1C so an overrun is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl   <= '0;
            r_rx_ovf <= 1'b0;
            r_tx_ovf <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_ctrl <= wdata[2:0];
            r_rx_ovf <= w_rx_ovf_set | (r_rx_ovf & ~(w_wr_status & wdata[c_st_rx_ovf]));
            r_tx_ovf <= w_tx_ovf_set | (r_tx_ovf & ~(w_wr_status & wdata[c_st_tx_ovf]));
            r_irq    <= (r_ctrl[c_ctrl_rx_irq_en] & ~w_rx_empty) |
                        (r_ctrl[c_ctrl_tx_irq_en] & w_tx_empty & (r_state == TX_IDLE));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= TX_IDLE;
            r_tx_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_tx_pop) r_tx_data <= w_tx_head;
        end
    end

    // A flush on the pop edge empties the queue, so nothing is dispatched.
    always_comb begin
        w_state_next = r_state;
        w_tx_pop     = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (!w_tx_empty && !w_tx_flush) begin
                    w_tx_pop     = 1'b1;
                    w_state_next = TX_START;
                end
            end
            TX_START: w_state_next = TX_BUSY;
            TX_BUSY:  if (tx_done) w_state_next = TX_IDLE;
            default:  w_state_next = TX_IDLE;
        endcase
    end

    // Data/parity fields of RXDATA read as zero while the RX FIFO is empty.
    always_comb begin
        rdata = '0;
        case (reg_sel)
            c_sel_ctrl: rdata[2:0] = r_ctrl;
            c_sel_rxdata: begin
                if (!w_rx_empty) begin
                    rdata[8:0]             = 9'(w_rx_head[DATA_W-1:0]);
                    rdata[c_rx_parity_bit] = w_rx_head[DATA_W];
                    rdata[c_rx_valid_bit]  = 1'b1;
                end
            end
            c_sel_status: begin
                rdata[c_st_rx_empty]          = w_rx_empty;
                rdata[c_st_rx_full]           = w_rx_full;
                rdata[c_st_tx_empty]          = w_tx_empty;
                rdata[c_st_tx_full]           = w_tx_full;
                rdata[c_st_tx_busy]           = (r_state != TX_IDLE);
                rdata[c_st_rx_ovf]            = r_rx_ovf;
                rdata[c_st_tx_ovf]            = r_tx_ovf;
                rdata[c_st_rx_cnt_lsb +: 8]   = 8'(w_rx_count);
                rdata[c_st_tx_cnt_lsb +: 8]   = 8'(w_tx_count);
            end
            default: rdata = '0;
        endcase
    end

    assign tx_data      = r_tx_data;
    assign tx_start     = (r_state == TX_START);
    assign tx_parity_en = r_ctrl[c_ctrl_parity_en];
    assign irq          = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_uart_mmio_fifo_regs.sv
// ============================================================================
// Module   : tb_uart_mmio_fifo_regs
// Brief    : Directed and random stimulus against a queue-based reference
//            model of the UART register front-end.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_mmio_fifo_regs;

    localparam int RXD = 8;
    localparam int TXD = 8;
    localparam logic [1:0] SEL_CTRL = 2'b00;
    localparam logic [1:0] SEL_TX   = 2'b01;
    localparam logic [1:0] SEL_RX   = 2'b10;
    localparam logic [1:0] SEL_ST   = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  reg_sel = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  rx_data = '0;
    logic        rx_parity_err = 1'b0;
    logic        rx_done = 1'b0;
    logic        tx_done = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_parity_en;
    logic        tx_start;
    logic        irq;

    always #5 clk = ~clk;

    uart_mmio_fifo_regs #(.DATA_W(8), .RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
        .clk           (clk),
        .reset         (rst),
        .reg_sel       (reg_sel),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .wdata         (wdata),
        .rdata         (rdata),
        .rx_data       (rx_data),
        .rx_parity_err (rx_parity_err),
        .rx_done       (rx_done),
        .tx_done       (tx_done),
        .tx_data       (tx_data),
        .tx_parity_en  (tx_parity_en),
        .tx_start      (tx_start),
        .irq           (irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: FIFOs as queues, transmitter as a phase number.
    logic [8:0]  m_rxq[$];
    logic [7:0]  m_txq[$];
    logic [2:0]  m_ctrl;
    bit          m_rx_ovf, m_tx_ovf, m_irq;
    int          m_phase;          // 0 idle, 1 start pulse, 2 waiting for tx_done
    logic [7:0]  m_tx_data;
    logic [7:0]  sent_q[$];
    logic [31:0] last_rdata;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_rxq.delete();
        m_txq.delete();
        m_ctrl = '0; m_rx_ovf = 0; m_tx_ovf = 0; m_irq = 0;
        m_phase = 0; m_tx_data = '0;
    endtask

    function automatic logic [31:0] exp_rdata(input logic [1:0] sel);
        logic [31:0] e;
        e = '0;
        case (sel)
            SEL_CTRL: e[2:0] = m_ctrl;
            SEL_RX: if (m_rxq.size() != 0) e = {21'b0, 1'b1, m_rxq[0][8], 1'b0, m_rxq[0][7:0]};
            SEL_ST: begin
                e[0] = (m_rxq.size() == 0);
                e[1] = (m_rxq.size() == RXD);
                e[2] = (m_txq.size() == 0);
                e[3] = (m_txq.size() == TXD);
                e[4] = (m_phase != 0);
                e[5] = m_rx_ovf;
                e[6] = m_tx_ovf;
                e[15:8]  = 8'(m_rxq.size());
                e[23:16] = 8'(m_txq.size());
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic model_update(input logic [1:0] sel, input logic wr, input logic rd,
                                input logic [31:0] wd, input logic rxd, input logic [7:0] rxv,
                                input logic rxp, input logic txd);
        bit wr_ctrl, rxf, txf, irq_n, rx_pop, fsm_pop, tx_push, w1c, rx_set, tx_set;
        logic [7:0] head;
        head    = '0;
        rx_set  = 0;
        tx_set  = 0;
        wr_ctrl = wr && sel == SEL_CTRL;
        rxf     = wr_ctrl && wd[3];
        txf     = wr_ctrl && wd[4];
        w1c     = wr && sel == SEL_ST;
        irq_n   = (m_ctrl[1] && m_rxq.size() != 0) ||
                  (m_ctrl[2] && m_txq.size() == 0 && m_phase == 0);
        rx_pop  = rd && sel == SEL_RX && m_rxq.size() != 0 && !rxf;
        fsm_pop = m_phase == 0 && m_txq.size() != 0 && !txf;
        tx_push = wr && sel == SEL_TX;
        if (rxf) m_rxq.delete();
        else begin
            if (rx_pop) void'(m_rxq.pop_front());
            if (rxd) begin
                if (m_rxq.size() < RXD) m_rxq.push_back({rxp, rxv});
                else rx_set = 1;
            end
        end
        if (txf) m_txq.delete();
        else begin
            if (fsm_pop) head = m_txq.pop_front();
            if (tx_push) begin
                if (m_txq.size() < TXD) m_txq.push_back(wd[7:0]);
                else tx_set = 1;
            end
        end
        m_rx_ovf = rx_set || (m_rx_ovf && !(w1c && wd[5]));
        m_tx_ovf = tx_set || (m_tx_ovf && !(w1c && wd[6]));
        if (wr_ctrl) m_ctrl = wd[2:0];
        if (m_phase == 0) begin
            if (fsm_pop) begin m_phase = 1; m_tx_data = head; end
        end else if (m_phase == 1) m_phase = 2;
        else if (txd) m_phase = 0;
        m_irq = irq_n;
    endtask

    // One bus cycle: drive, check rdata before the edge, step model, check outputs.
    task automatic cyc(input logic [1:0] sel, input logic wr, input logic rd, input logic [31:0] wd,
                       input logic rxd, input logic [7:0] rxv, input logic rxp, input logic txd);
        reg_sel = sel; wr_en = wr; rd_en = rd; wdata = wd;
        rx_done = rxd; rx_data = rxv; rx_parity_err = rxp; tx_done = txd;
        #2;
        last_rdata = rdata;
        if (sel == SEL_RX && m_rxq.size() == 0) check_val("rdata_rx_empty", rdata & 32'h400, 32'h0);
        else check_val("rdata", rdata, exp_rdata(sel));
        @(posedge clk);
        model_update(sel, wr, rd, wd, rxd, rxv, rxp, txd);
        #1;
        if (tx_start) sent_q.push_back(tx_data);
        check_val("tx_start", 32'(tx_start), 32'(m_phase == 1));
        check_val("tx_data", 32'(tx_data), 32'(m_tx_data));
        check_val("irq", 32'(irq), 32'(m_irq));
        check_val("parity_en", 32'(tx_parity_en), 32'(m_ctrl[0]));
        wr_en = 0; rd_en = 0; rx_done = 0; tx_done = 0;
    endtask

    task automatic do_reset();
        rst = 1; wr_en = 0; rd_en = 0; rx_done = 0; tx_done = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        logic [31:0] wd;
        do_reset();
        reg_sel = SEL_ST;
        #1;
        check_val("reset_status", rdata, 32'h0000_0005);
        check_val("reset_outputs", {tx_data, 6'b0, tx_start, irq}, 32'h0);

        // TX ordering through the dispatch FSM
        sent_q.delete();
        for (int i = 0; i < 3; i++) cyc(SEL_TX, 1, 0, 32'h41 + i, 0, 0, 0, 0);
        for (int n = 0; n < 80 && !(sent_q.size() == 3 && m_phase == 0); n++)
            cyc(SEL_ST, 0, 0, 0, 0, 0, 0, (m_phase == 2) && ($urandom_range(0, 2) == 0));
        check_val("tx_sent_count", 32'(sent_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < sent_q.size(); i++)
            check_val("tx_sent_order", 32'(sent_q[i]), 32'h41 + i);

        // RX overflow and drain
        do_reset();
        for (int i = 0; i < 9; i++) cyc(SEL_ST, 0, 0, 0, 1, 8'h10 + 8'(i), 0, 0);
        cyc(SEL_ST, 0, 0, 0, 0, 0, 0, 0);
        check_val("rx_full_ovf", last_rdata & 32'h22, 32'h22);
        for (int i = 0; i < 9; i++) begin
            cyc(SEL_RX, 0, 1, 0, 0, 0, 0, 0);
            if (i < 8) check_val("rx_drain", last_rdata, 32'h400 + 32'h10 + i);
            else check_val("rx_drain_empty", last_rdata & 32'h400, 32'h0);
        end
        cyc(SEL_ST, 1, 0, 32'h20, 0, 0, 0, 0);
        cyc(SEL_ST, 0, 0, 0, 0, 0, 0, 0);
        check_val("rx_ovf_w1c", last_rdata & 32'h20, 32'h0);

        // Push into a full RX FIFO together with a pop
        for (int i = 0; i < 8; i++) cyc(SEL_ST, 0, 0, 0, 1, 8'h20 + 8'(i), 0, 0);
        cyc(SEL_RX, 0, 1, 0, 1, 8'h77, 0, 0);
        cyc(SEL_ST, 0, 0, 0, 0, 0, 0, 0);
        check_val("rx_full_pushpop", last_rdata & 32'hFF20, 32'h0800);
        for (int i = 0; i < 8; i++) cyc(SEL_RX, 0, 1, 0, 0, 0, 0, 0);
        check_val("rx_tail_word", last_rdata, 32'h477);

        // Parity error bit
        cyc(SEL_ST, 0, 0, 0, 1, 8'h5A, 1, 0);
        cyc(SEL_RX, 0, 1, 0, 0, 0, 0, 0);
        check_val("rx_parity_read", last_rdata, 32'h0000_065A);

        // Interrupts
        do_reset();
        cyc(SEL_CTRL, 1, 0, 32'h02, 0, 0, 0, 0);
        cyc(SEL_ST, 0, 0, 0, 1, 8'h33, 0, 0);
        cyc(SEL_ST, 0, 0, 0, 0, 0, 0, 0);
        check_val("irq_rx_set", 32'(irq), 32'd1);
        cyc(SEL_RX, 0, 1, 0, 0, 0, 0, 0);
        cyc(SEL_ST, 0, 0, 0, 0, 0, 0, 0);
        check_val("irq_rx_clear", 32'(irq), 32'd0);
        cyc(SEL_CTRL, 1, 0, 32'h04, 0, 0, 0, 0);
        cyc(SEL_ST, 0, 0, 0, 0, 0, 0, 0);
        check_val("irq_tx_idle", 32'(irq), 32'd1);

        // Asynchronous reset in the middle of a frame
        do_reset();
        cyc(SEL_CTRL, 1, 0, 32'h02, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(SEL_TX, 1, 0, 32'hA0 + i, i == 0, 8'h11, 0, 0);
        for (int n = 0; n < 20 && m_phase != 2; n++) cyc(SEL_ST, 0, 0, 0, 0, 0, 0, 0);
        check_val("mid_busy_reached", 32'(m_phase), 32'd2);
        check_val("mid_irq_before", 32'(irq), 32'd1);
        reg_sel = SEL_ST;
        #2;
        rst = 1;
        #1;
        check_val("rst_tx_start", 32'(tx_start), 32'd0);
        check_val("rst_tx_data", 32'(tx_data), 32'd0);
        check_val("rst_irq", 32'(irq), 32'd0);
        check_val("rst_status", rdata, 32'h0000_0005);
        reg_sel = SEL_CTRL;
        #1;
        check_val("rst_ctrl", rdata, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] sel;
            sel = 2'($urandom_range(0, 3));
            wd  = $urandom;
            if (sel == SEL_CTRL && $urandom_range(0, 7) != 0) wd[4:3] = 2'b00;
            cyc(sel, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, wd,
                $urandom_range(0, 1) == 0, 8'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
